// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding, geometry helpers and address field slicing for cache_ctrl_param.
// Field helpers work on a wide zero-extended address so one package serves every parameter set.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPARE = 3'd1,
    S_WB      = 3'd2,
    S_FILL    = 3'd3,
    S_RETRY   = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  localparam int FW = 64;

  function automatic int calc_tag_w(input int addr_w, input int index_w, input int off_w);
    return addr_w - index_w - off_w;
  endfunction

  function automatic int calc_words(input int off_w);
    return 1 << (off_w - 1);
  endfunction

  function automatic logic [FW-1:0] field_mask(input int w);
    return (w >= FW) ? '1 : ((FW'(1) << w) - FW'(1));
  endfunction

  // Index occupies the top bits, offset the bottom, tag whatever lies between.
  function automatic logic [FW-1:0] get_index(input logic [FW-1:0] a, input int addr_w,
                                              input int index_w);
    return (a >> (addr_w - index_w)) & field_mask(index_w);
  endfunction

  function automatic logic [FW-1:0] get_tag(input logic [FW-1:0] a, input int addr_w,
                                            input int index_w, input int off_w);
    return (a >> off_w) & field_mask(calc_tag_w(addr_w, index_w, off_w));
  endfunction

  function automatic logic [FW-1:0] get_offset(input logic [FW-1:0] a, input int off_w);
    return a & field_mask(off_w);
  endfunction

endpackage

// File: rtl/dff.sv
// Generic register with asynchronous active-high reset to a parameterised value.
// One-cycle latency, no backpressure.
module dff #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/mem_return_tracker.sv
// Delays each accepted memory read by LAT cycles to mark when its data is on DataOut_mem.
// Fixed LAT-cycle latency; memory returns cannot be stalled, so there is no backpressure.
module mem_return_tracker #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic acc,
  output logic ret
);

  logic [LAT-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else     pipe <= LAT'({pipe, acc});
  end

  assign ret = pipe[LAT-1];

endmodule

// File: rtl/cache_ctrl_param.sv
// Direct-mapped write-back cache controller: hit in 1 cycle, miss refills a line with pipelined reads.
// Memory requests hold while stall is high; Stall_sys holds off the processor outside IDLE.
module cache_ctrl_param
  import cache_ctrl_pkg::*;
#(
  parameter  int ADDR_W  = 16,
  parameter  int DATA_W  = 16,
  parameter  int INDEX_W = 8,
  parameter  int OFF_W   = 3,
  parameter  int MEM_LAT = 2,
  localparam int TAG_W   = calc_tag_w(ADDR_W, INDEX_W, OFF_W),
  localparam int WORDS   = calc_words(OFF_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  Addr,
  input  logic [DATA_W-1:0]  DataIn,
  input  logic               Rd,
  input  logic               Wr,
  output logic               Done,
  output logic               CacheHit,
  output logic               Stall_sys,
  output logic               err,
  input  logic               hit,
  input  logic               dirty,
  input  logic               valid,
  input  logic [TAG_W-1:0]   tag_out,
  input  logic [DATA_W-1:0]  DataOut_cache,
  output logic               enable_ct,
  output logic               cmp_ct,
  output logic               wr_cache,
  output logic               valid_in_ct,
  output logic [INDEX_W-1:0] index_cache,
  output logic [OFF_W-1:0]   offset_cache,
  output logic [TAG_W-1:0]   tag_cache,
  output logic [DATA_W-1:0]  DataIn_ct,
  input  logic [DATA_W-1:0]  DataOut_mem,
  input  logic               stall,
  output logic [ADDR_W-1:0]  Addr_mem,
  output logic [DATA_W-1:0]  DataIn_mem,
  output logic               wr_mem,
  output logic               rd_mem
);

  // i and j need one extra bit so they can reach WORDS and mark completion.
  localparam logic [OFF_W-1:0] WORDS_C = OFF_W'(WORDS);
  localparam logic [OFF_W-1:0] LAST_C  = OFF_W'(WORDS - 1);
  localparam logic [OFF_W-2:0] K_LAST  = '1;

  state_t                   state, nstate;
  logic [$bits(state_t)-1:0] state_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [DATA_W-1:0]        data_q;
  logic                     wr_q;
  logic [OFF_W-2:0]         k_q;
  logic [OFF_W-1:0]         i_q, j_q;
  logic [INDEX_W-1:0]       idx_q;
  logic [TAG_W-1:0]         tag_q;
  logic [OFF_W-1:0]         off_q;
  logic                     rd_acc, ret_vld;

  assign idx_q = INDEX_W'(get_index(FW'(addr_q), ADDR_W, INDEX_W));
  assign tag_q = TAG_W'(get_tag(FW'(addr_q), ADDR_W, INDEX_W, OFF_W));
  assign off_q = OFF_W'(get_offset(FW'(addr_q), OFF_W));

  dff #(.W($bits(state_t)), .RST_VAL(S_IDLE)) u_state_reg (
    .clk (clk),
    .rst (rst),
    .d   (nstate),
    .q   (state_q)
  );
  assign state = state_t'(state_q);

  assign rd_acc = rd_mem & ~stall;

  mem_return_tracker #(.LAT(MEM_LAT)) u_ret (
    .clk (clk),
    .rst (rst),
    .acc (rd_acc),
    .ret (ret_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
    end else if (state == S_IDLE && (Rd ^ Wr)) begin
      addr_q <= Addr;
      data_q <= DataIn;
      wr_q   <= Wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end else begin
      if (state == S_WB) begin
        if (!stall) k_q <= k_q + (OFF_W-1)'(1);
      end else begin
        k_q <= '0;
      end
      if (state == S_FILL) begin
        if (rd_acc)  i_q <= i_q + OFF_W'(1);
        if (ret_vld) j_q <= j_q + OFF_W'(1);
      end else begin
        i_q <= '0;
        j_q <= '0;
      end
    end
  end

  always_comb begin
    nstate       = state;
    Done         = 1'b0;
    CacheHit     = 1'b0;
    err          = 1'b0;
    Stall_sys    = (state != S_IDLE);
    enable_ct    = 1'b0;
    cmp_ct       = 1'b0;
    wr_cache     = 1'b0;
    valid_in_ct  = 1'b0;
    index_cache  = '0;
    offset_cache = '0;
    tag_cache    = '0;
    DataIn_ct    = '0;
    Addr_mem     = '0;
    DataIn_mem   = '0;
    wr_mem       = 1'b0;
    rd_mem       = 1'b0;
    case (state)
      S_IDLE: begin
        if (Rd & Wr)      nstate = S_ERR;
        else if (Rd ^ Wr) nstate = S_COMPARE;
      end
      // RETRY repeats the compare access so a pending write merges into the fresh line.
      S_COMPARE, S_RETRY: begin
        enable_ct    = 1'b1;
        cmp_ct       = 1'b1;
        wr_cache     = wr_q;
        DataIn_ct    = data_q;
        index_cache  = idx_q;
        tag_cache    = tag_q;
        offset_cache = off_q;
        if (state == S_RETRY) begin
          Done   = 1'b1;
          nstate = S_IDLE;
        end else if (hit & valid) begin
          Done     = 1'b1;
          CacheHit = 1'b1;
          nstate   = S_IDLE;
        end else if (valid & dirty) begin
          nstate = S_WB;
        end else begin
          nstate = S_FILL;
        end
      end
      S_WB: begin
        enable_ct    = 1'b1;
        index_cache  = idx_q;
        offset_cache = {k_q, 1'b0};
        wr_mem       = 1'b1;
        Addr_mem     = {idx_q, tag_out, k_q, 1'b0};
        DataIn_mem   = DataOut_cache;
        if (!stall && k_q == K_LAST) nstate = S_FILL;
      end
      S_FILL: begin
        if (i_q < WORDS_C) begin
          rd_mem   = 1'b1;
          Addr_mem = {idx_q, tag_q, i_q[OFF_W-2:0], 1'b0};
        end
        // Only the final word validates the line, so an aborted refill leaves it invalid.
        if (ret_vld) begin
          enable_ct    = 1'b1;
          wr_cache     = 1'b1;
          index_cache  = idx_q;
          tag_cache    = tag_q;
          offset_cache = {j_q[OFF_W-2:0], 1'b0};
          DataIn_ct    = DataOut_mem;
          valid_in_ct  = (j_q == LAST_C);
          if (j_q == LAST_C) nstate = S_RETRY;
        end
      end
      S_ERR: begin
        Done   = 1'b1;
        err    = 1'b1;
        nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_param.sv
// Scoreboard bench for cache_ctrl_param with behavioural cache array and latency-2 memory.
module tb_cache_ctrl_param;

  localparam int ADDR_W = 16, DATA_W = 16, INDEX_W = 8, OFF_W = 3, MEM_LAT = 2;
  localparam int TAG_W = 5;

  logic clk, rst;
  logic [15:0] Addr, DataIn;
  logic Rd, Wr, Done, CacheHit, Stall_sys, err;
  logic hit, dirty, valid;
  logic [TAG_W-1:0] tag_out, tag_cache;
  logic [15:0] DataOut_cache, DataIn_ct, DataOut_mem, Addr_mem, DataIn_mem;
  logic enable_ct, cmp_ct, wr_cache, valid_in_ct, stall, wr_mem, rd_mem;
  logic [7:0] index_cache;
  logic [2:0] offset_cache;

  cache_ctrl_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .OFF_W(OFF_W),
                     .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .Done(Done), .CacheHit(CacheHit), .Stall_sys(Stall_sys), .err(err),
    .hit(hit), .dirty(dirty), .valid(valid), .tag_out(tag_out), .DataOut_cache(DataOut_cache),
    .enable_ct(enable_ct), .cmp_ct(cmp_ct), .wr_cache(wr_cache), .valid_in_ct(valid_in_ct),
    .index_cache(index_cache), .offset_cache(offset_cache), .tag_cache(tag_cache),
    .DataIn_ct(DataIn_ct), .DataOut_mem(DataOut_mem), .stall(stall), .Addr_mem(Addr_mem),
    .DataIn_mem(DataIn_mem), .wr_mem(wr_mem), .rd_mem(rd_mem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [79:0] outs();
    return 80'({Done, CacheHit, Stall_sys, err, enable_ct, cmp_ct, wr_cache, valid_in_ct,
                wr_mem, rd_mem, index_cache, offset_cache, tag_cache, DataIn_ct, Addr_mem,
                DataIn_mem});
  endfunction

  // Behavioural cache array
  logic [TAG_W-1:0] c_tag [256];
  logic             c_vld [256];
  logic             c_dty [256];
  logic [15:0]      c_dat [256][4];
  logic             pl_en, pl_vld, pl_dty;
  logic [7:0]       pl_idx;
  logic [TAG_W-1:0] pl_tag;
  logic [15:0]      pl_base;

  assign tag_out       = c_tag[index_cache];
  assign valid         = c_vld[index_cache];
  assign dirty         = c_dty[index_cache];
  assign hit           = (c_tag[index_cache] == tag_cache);
  assign DataOut_cache = c_dat[index_cache][offset_cache[2:1]];

  always @(posedge clk) begin
    if (pl_en) begin
      c_tag[pl_idx] <= pl_tag;
      c_vld[pl_idx] <= pl_vld;
      c_dty[pl_idx] <= pl_dty;
      for (int w = 0; w < 4; w++) c_dat[pl_idx][w] <= pl_base + 16'(w);
    end else if (enable_ct && wr_cache) begin
      if (cmp_ct) begin
        if (hit && valid) begin
          c_dat[index_cache][offset_cache[2:1]] <= DataIn_ct;
          c_dty[index_cache] <= 1'b1;
        end
      end else begin
        c_dat[index_cache][offset_cache[2:1]] <= DataIn_ct;
        c_tag[index_cache] <= tag_cache;
        c_vld[index_cache] <= valid_in_ct;
        c_dty[index_cache] <= 1'b0;
      end
    end
  end

  // Memory: word at address a reads as a ^ 5A5A, MEM_LAT cycles after acceptance.
  int          md_q[$];
  logic [15:0] ma_q[$];
  always @(posedge clk) begin
    if (rst) begin
      md_q.delete();
      ma_q.delete();
      DataOut_mem <= 16'hDEAD;
    end else begin
      if (rd_mem && !stall) begin
        md_q.push_back(cyc + MEM_LAT);
        ma_q.push_back(Addr_mem);
      end
      if (md_q.size() > 0 && md_q[0] == cyc + 1) begin
        DataOut_mem <= ma_q[0] ^ 16'h5A5A;
        void'(md_q.pop_front());
        void'(ma_q.pop_front());
      end else begin
        DataOut_mem <= 16'hDEAD;
      end
    end
  end

  typedef struct { int t0; int lat; logic hit; logic err; logic dchk; logic [15:0] dat; } done_t;
  typedef struct { logic w; logic [15:0] a; logic [15:0] d; } mop_t;
  typedef struct { logic [2:0] off; logic [15:0] d; logic vin; } fill_t;

  done_t dq[$];
  mop_t  mq_exp[$];
  fill_t fq[$];
  done_t mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (Done) begin
        done_cnt++;
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: Done=1 at cycle %0d, none expected", cyc);
        end else begin
          mon_e = dq.pop_front();
          chk("done_latency", 80'(cyc - mon_e.t0), 80'(mon_e.lat));
          chk("cache_hit", 80'(CacheHit), 80'(mon_e.hit));
          chk("err", 80'(err), 80'(mon_e.err));
          if (mon_e.dchk) chk("read_data", 80'(DataOut_cache), 80'(mon_e.dat));
        end
      end
      if (rd_mem || wr_mem) begin
        if (mq_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected: strobe at addr %0h, none expected", Addr_mem);
        end else begin
          chk("mem_wr", 80'(wr_mem), 80'(mq_exp[0].w));
          chk("mem_rd", 80'(rd_mem), 80'(!mq_exp[0].w));
          chk("mem_addr", 80'(Addr_mem), 80'(mq_exp[0].a));
          if (mq_exp[0].w) chk("mem_data", 80'(DataIn_mem), 80'(mq_exp[0].d));
          if (!stall) void'(mq_exp.pop_front());
        end
      end
      if (enable_ct && wr_cache && !cmp_ct) begin
        if (fq.size() == 0) begin
          checks++; errors++;
          $display("FAIL fill_unexpected: cache fill at offset %0h, none expected", offset_cache);
        end else begin
          chk("fill_offset", 80'(offset_cache), 80'(fq[0].off));
          chk("fill_data", 80'(DataIn_ct), 80'(fq[0].d));
          chk("fill_valid_in", 80'(valid_in_ct), 80'(fq[0].vin));
          void'(fq.pop_front());
        end
      end
    end
  end

  task automatic push_mem(input logic w, input logic [15:0] a, input logic [15:0] d);
    mop_t m;
    m.w = w; m.a = a; m.d = d;
    mq_exp.push_back(m);
  endtask

  task automatic push_fill(input logic [2:0] off, input logic [15:0] d, input logic vin);
    fill_t f;
    f.off = off; f.d = d; f.vin = vin;
    fq.push_back(f);
  endtask

  task automatic push_refill(input logic [15:0] base, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3);
    logic [15:0] dd [4];
    dd = '{d0, d1, d2, d3};
    for (int w = 0; w < 4; w++) push_mem(1'b0, base + 16'(2 * w), 16'h0);
    for (int w = 0; w < 4; w++) push_fill(3'(2 * w), dd[w], (w == 3));
  endtask

  task automatic push_wb(input logic [15:0] base, input logic [15:0] d0);
    for (int w = 0; w < 4; w++) push_mem(1'b1, base + 16'(2 * w), d0 + 16'(w));
  endtask

  task automatic preload(input logic [7:0] idx, input logic [TAG_W-1:0] tg, input logic v,
                         input logic d, input logic [15:0] base);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = idx; pl_tag = tg; pl_vld = v; pl_dty = d; pl_base = base;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic run(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                     input int lat, input logic ehit, input logic eerr, input logic edchk,
                     input logic [15:0] edat, input int st_at, input int st_len, input int rst_at);
    done_t e;
    int dc0;
    @(posedge clk); #1;
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    if (lat > 0) begin
      e.t0 = cyc; e.lat = lat; e.hit = ehit; e.err = eerr; e.dchk = edchk; e.dat = edat;
      dq.push_back(e);
    end
    dc0 = done_cnt;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      Rd = 1'b0; Wr = 1'b0; Addr = 16'hFFFF; DataIn = 16'h1234;
      stall = (n >= st_at) && (n < st_at + st_len);
      if (n == rst_at) begin
        rst = 1'b1;
        #2;
        chk("abort_reset_outputs", outs(), 80'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      if (done_cnt != dc0) break;
    end
    stall = 1'b0;
    if (rst_at < 0 && done_cnt == dc0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no Done within 40 cycles for addr %0h", a);
    end
    chk("mem_ops_outstanding", 80'(mq_exp.size()), 80'(0));
    chk("fills_outstanding", 80'(fq.size()), 80'(0));
  endtask

  initial begin
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0; stall = 1'b0;
    pl_en = 1'b0; pl_vld = 1'b0; pl_dty = 1'b0; pl_idx = '0; pl_tag = '0; pl_base = '0;
    @(posedge clk); #1;
    chk("reset_outputs", outs(), 80'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    preload(8'h12, 5'h05, 1'b1, 1'b0, 16'h1200);
    preload(8'h34, 5'h1F, 1'b1, 1'b0, 16'hD000);

    // Read hit: word 1 of line 0x12
    run(1'b1, 1'b0, 16'h122A, 16'h0, 1, 1'b1, 1'b0, 1'b1, 16'h1201, 0, 0, -1);

    // Write miss to a clean line, then read back the merged word as a hit
    push_refill(16'h3410, 16'h6E4A, 16'h6E48, 16'h6E4E, 16'h6E4C);
    run(1'b0, 1'b1, 16'h3410, 16'hBEEF, 8, 1'b0, 1'b0, 1'b0, 16'h0, 0, 0, -1);
    run(1'b1, 1'b0, 16'h3410, 16'h0, 1, 1'b1, 1'b0, 1'b1, 16'hBEEF, 0, 0, -1);

    // Illegal request
    run(1'b1, 1'b1, 16'h3410, 16'h0, 1, 1'b0, 1'b1, 1'b0, 16'h0, 0, 0, -1);

    // Read miss with dirty victim tag 0x1F
    preload(8'h34, 5'h1F, 1'b1, 1'b1, 16'hD000);
    push_wb(16'h34F8, 16'hD000);
    push_refill(16'h3400, 16'h6E5A, 16'h6E58, 16'h6E5E, 16'h6E5C);
    run(1'b1, 1'b0, 16'h3402, 16'h0, 12, 1'b0, 1'b0, 1'b1, 16'h6E58, 0, 0, -1);

    // Same dirty miss with memory stalled for 3 cycles on write-back word 1
    preload(8'h34, 5'h1F, 1'b1, 1'b1, 16'hD000);
    push_wb(16'h34F8, 16'hD000);
    push_refill(16'h3400, 16'h6E5A, 16'h6E58, 16'h6E5E, 16'h6E5C);
    run(1'b1, 1'b0, 16'h3402, 16'h0, 15, 1'b0, 1'b0, 1'b1, 16'h6E58, 3, 3, -1);

    // Reset after the second refill return; the line must stay invalid
    for (int w = 0; w < 4; w++) push_mem(1'b0, 16'h1200 + 16'(2 * w), 16'h0);
    push_fill(3'd0, 16'h485A, 1'b0);
    push_fill(3'd2, 16'h4858, 1'b0);
    run(1'b1, 1'b0, 16'h1200, 16'h0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 0, 0, 6);
    chk("abort_no_done_pending", 80'(dq.size()), 80'(0));

    push_refill(16'h1200, 16'h485A, 16'h4858, 16'h485E, 16'h485C);
    run(1'b1, 1'b0, 16'h1200, 16'h0, 8, 1'b0, 1'b0, 1'b1, 16'h485A, 0, 0, -1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

endmodule

// File: doc/cache_ctrl_param.md
# cache_ctrl_param

Parametrised direct-mapped write-back cache controller. It sits between the processor memory port and two neighbours: the cache data/tag array and the banked main memory. It generalises the fixed 16-bit, 4-word-line controller with configurable address, data and line geometry and a configurable memory read latency. Compared with that controller it adds memory-stall handshaking, pipelined refill, illegal-request detection and safe abort of a refill on reset.

## Interface
**Parameters**
- ADDR_W, default 16: address width.
- DATA_W, default 16: word width.
- INDEX_W, default 8: index width. Index = Addr[ADDR_W-1 -: INDEX_W].
- OFF_W, default 3: byte-offset width. Offset = Addr[OFF_W-1:0].
  - Words per line: WORDS = 2^(OFF_W-1).
  - Tag = the remaining middle bits, TAG_W = ADDR_W-INDEX_W-OFF_W.
- MEM_LAT, default 2: cycles from an accepted memory read to valid DataOut_mem. Legal range ≥1.

**Ports**

Clock and reset:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-high reset.

Processor side:
- Addr, in, ADDR_W: request address.
- DataIn, in, DATA_W: request write data.
- Rd, in, 1: read request.
- Wr, in, 1: write request.
- Done, out, 1: request complete.
- CacheHit, out, 1: request completed as a hit.
- Stall_sys, out, 1: controller busy.
- err, out, 1: illegal request.

Cache side:
- hit, in, 1; dirty, in, 1; valid, in, 1: compare results and line status.
- tag_out, in, TAG_W: stored tag of the indexed line.
- DataOut_cache, in, DATA_W: cache read data.
- enable_ct, cmp_ct, wr_cache, valid_in_ct, out, 1 each: cache control strobes.
- index_cache, out, INDEX_W; offset_cache, out, OFF_W; tag_cache, out, TAG_W: cache address.
- DataIn_ct, out, DATA_W: cache write data.

Memory side:
- DataOut_mem, in, DATA_W: memory read data.
- stall, in, 1: memory cannot accept a request this cycle.
- Addr_mem, out, ADDR_W; DataIn_mem, out, DATA_W: memory address and write data.
- wr_mem, rd_mem, out, 1 each: memory request strobes.

## Operation
- **States:** IDLE, COMPARE, WB, FILL, RETRY, ERR.
- **IDLE**
  - Stall_sys=0.
  - On Rd^Wr: latch Addr, DataIn and the operation into request registers, then go to COMPARE.
  - On Rd&Wr: go to ERR.
- **ERR:** err=1, Done=1, no cache or memory access, then back to IDLE.
- **COMPARE:** enable_ct=1, cmp_ct=1, wr_cache=latched Wr, DataIn_ct=latched DataIn, index/tag/offset from the latched address.
  - hit&valid: Done=1, CacheHit=1 in this cycle, then IDLE.
  - Miss with valid&dirty: go to WB.
  - Any other miss: go to FILL.
- **WB:** word counter k runs 0..WORDS-1.
  - Drive enable_ct=1, offset_cache={k,1'b0}, wr_mem=1, Addr_mem={index,tag_out,k,1'b0}, DataIn_mem=DataOut_cache.
  - k advances only when !stall.
  - After word WORDS-1 is accepted, go to FILL.
- **FILL:** issue counter i and return counter j, both starting at 0.
  - Issue: rd_mem=1 with Addr_mem={index,tag,i,1'b0} while i<WORDS. i advances when !stall.
  - Return: each accepted read returns exactly MEM_LAT cycles later. On return, write the cache: wr_cache=1, offset_cache={j,1'b0}, tag_cache=latched tag, DataIn_ct=DataOut_mem. Then j++.
  - valid_in_ct=1 only on the return of word WORDS-1. Earlier words write with valid_in_ct=0, so an aborted refill leaves the line invalid.
  - Returns arrive regardless of stall. Issue and return may overlap in the same cycle.
  - When j reaches WORDS, go to RETRY.
- **RETRY:** same cache drive as COMPARE (a write merges DataIn). Done=1, CacheHit=0, then IDLE.
- **Stall_sys** is 1 in every state except IDLE.
- **Idle values:** unused buses drive 0, not X.

## Timing
- **Reset:** rst drives all outputs to 0 immediately, clears the state to IDLE and clears all counters. A reset mid-WB or mid-FILL abandons the request with no Done.
- **Hit latency:** request sampled in cycle 0, Done in cycle 1.
- **Clean-miss latency (no stall):** Done at cycle 2+WORDS+MEM_LAT.
- **Dirty miss:** adds WORDS cycles, plus one cycle per stalled cycle.
- **Memory handshake:** a request is accepted in a cycle where the strobe is high and stall is low. Address, data and strobe hold stable while stall is high.
- **Request inputs:** Rd, Wr, Addr and DataIn are ignored outside IDLE.

## Structure
- **Package cache_ctrl_pkg:** state encoding, field-slice helper functions (index/tag/offset), derived constants TAG_W and WORDS.
- **State register:** the team dff with asynchronous reset.
- **Sub-module mem_return_tracker:** MEM_LAT-deep shift register. Input is a read-accepted pulse; output is a return-valid pulse.
- **Main module:** FSM plus k, i and j counters.

## Test plan
- **Read hit:** preload line idx 0x12, tag 0x05. Rd, Addr=0x122A -> Done=1, CacheHit=1 in cycle 1, no memory strobes.
- **Write miss, clean line:** Wr, Addr=0x3410, DataIn=0xBEEF -> 4 rd_mem at 0x3410/12/14/16, 4 cache fills, valid_in_ct on the last fill only. Done at cycle 8 with CacheHit=0. A later read of 0x3410 returns 0xBEEF as a hit.
- **Read miss, dirty victim** (tag_out=0x1F, idx 0x34): Rd, Addr=0x3402 -> wr_mem to 0x34F8..0x34FE carrying the cache data, then the refill. Done at cycle 12.
- **Stall:** hold stall high 3 cycles during WB word 1 -> Addr_mem=0x34FA held stable, Done delayed exactly 3 cycles.
- **Illegal request:** Rd=Wr=1 -> err=1 and Done=1 in cycle 1, no strobes.
- **Reset mid-FILL:** rst after the 2nd return -> all outputs 0, state IDLE. A following read of the same address misses (line invalid).
